ara_fpga_rst_ctrl: RTL and testbench
====================================

// Module: ara_fpga_rst_ctrl
// PURPOSE
// - Reset sequencer for the FPGA top level. Generates the debug-module reset and the SoC/UART reset.
// - Inputs: board reset, PLL lock and the debug module's ndmreset request.
// - Staged release: PLL lock must be stable first, then the debug module leaves reset, then the SoC.
// - ndmreset is stretched to a guaranteed minimum width; DM state survives an ndmreset.
// PARAMETERS
// - SyncStages      2     synchronizer depth for pll_locked_i (>=2)
// - LockHoldCycles  1024  consecutive synced-lock cycles required before DM release (>=1)
// - SocRstCycles    64    cycles between DM release and SoC release (>=1)
// - NdmMinCycles    32    minimum SoC reset width on ndmreset (>=1)
// PORTS
// - clk_i        in   1  core clock (post-PLL BUFG)
// - rst_ni       in   1  asynchronous active-low reset (board sys_rst_n)
// - pll_locked_i in   1  PLL LOCKED, asynchronous to clk_i
// - ndmreset_i   in   1  dm_top ndmreset_o, synchronous to clk_i, active-high
// - dm_rst_no    out  1  active-low reset to dm_top
// - soc_rst_no   out  1  active-low reset to ara_soc and uart
// - rst_done_o   out  1  1 while in RUN
// - state_o      out  3  current FSM state (LED/debug)
// - rst_cause_o  out  2  last reset cause: 0 board/power-on, 1 ndmreset, 2 PLL lock loss
// BEHAVIOUR
// - Clocking and reset
//   - One clock. Reset is asynchronous and active-low.
//   - On rst_ni=0, immediately (asynchronously): dm_rst_no=0, soc_rst_no=0, rst_done_o=0, state=WAIT_LOCK, counter=0, rst_cause_o=0, synchronizer flops=0.
// - All outputs are registered and computed from the next state, so they change on the same edge as the state.
// - Counter
//   - Width $clog2(max(LockHoldCycles,SocRstCycles,NdmMinCycles))+1.
//   - Cleared on every state change. Saturates, never wraps.
// - pll_locked_i passes through SyncStages flops to give lock_s. No other input is synchronized.
// - States (state_o encoding)
//   - WAIT_LOCK=0: dm=0, soc=0. If lock_s=1 -> LOCK_HOLD.
//   - LOCK_HOLD=1: dm=0, soc=0. Counter increments while lock_s=1.
//     - If lock_s=0 -> WAIT_LOCK and the count restarts from 0.
//     - When count = LockHoldCycles-1 with lock_s=1 -> SOC_HOLD.
//   - SOC_HOLD=2: dm=1, soc=0.
//     - If ndmreset_i=1 -> NDM; this takes priority over the count.
//     - When count = SocRstCycles-1 -> RUN.
//   - RUN=3: dm=1, soc=1, rst_done_o=1. If ndmreset_i=1 -> NDM; soc_rst_no falls on that edge.
//   - NDM=4: dm=1, soc=0. Counter increments each cycle.
//     - Exit to SOC_HOLD when ndmreset_i=0 and count >= NdmMinCycles-1.
//     - SoC reset width is therefore max(NdmMinCycles, ndmreset high time) + SocRstCycles.
// - Timing
//   - dm_rst_no rises exactly LockHoldCycles cycles after LOCK_HOLD entry.
//   - soc_rst_no rises exactly SocRstCycles cycles after dm_rst_no.
// - rst_cause_o
//   - Set to 1 on entry to NDM; set to 2 on lock-loss (see CONFIGURATION).
//   - Holds its value otherwise. Reset only by rst_ni.
// - dm_rst_no never falls because of ndmreset_i; only rst_ni or lock loss can drop it.
// - Simultaneous events: lock loss (macro on) beats ndmreset_i, which beats counter expiry.
// - Unused encodings 5..7 -> WAIT_LOCK on the next edge with both resets asserted.
// CONFIGURATION
// - Macro ARA_FPGA_RST_LOCKMON_EN
// - Defined:
//   - In SOC_HOLD, RUN or NDM, lock_s=0 -> WAIT_LOCK; dm_rst_no=0, soc_rst_no=0 on that edge; rst_cause_o=2.
//   - Normal sequencing then restarts.
// - Undefined:
//   - lock_s is ignored outside WAIT_LOCK/LOCK_HOLD.
//   - rst_cause_o never takes value 2; the lock-loss logic is not synthesized.
// TESTING (SyncStages=2, LockHoldCycles=8, SocRstCycles=4, NdmMinCycles=6)
// - Power-on: rst_ni low 5 cycles then high, pll_locked_i=1 -> state 0->1; dm_rst_no=1 8 cycles after LOCK_HOLD entry; soc_rst_no=1 and rst_done_o=1 4 cycles later; cause=0.
// - Lock glitch: pll_locked_i low 1 cycle at LOCK_HOLD count 5 -> WAIT_LOCK, dm_rst_no stays 0; dm_rst_no rises a full 8 cycles after re-entry to LOCK_HOLD.
// - Short ndmreset: 1-cycle pulse in RUN -> soc_rst_no=0 next edge for exactly 6+4=10 cycles; dm_rst_no stays 1; cause=1.
// - Long ndmreset: held 20 cycles in RUN -> soc_rst_no low for 20 cycles + 4 (SOC_HOLD) then 1; ndmreset during SOC_HOLD re-enters NDM.
// - Async reset in SOC_HOLD count 2: rst_ni low mid-cycle -> dm_rst_no, soc_rst_no, rst_done_o =0 before the next edge; state_o=0; cause=0.
// - Lock loss in RUN: macro on -> both resets 0 within SyncStages+1 edges, cause=2, full resequence; macro off -> outputs unchanged.

Source files
------------

// File: rtl/ara_fpga_rst_ctrl.sv
// -----------------------------------------------------------------------------
// ara_fpga_rst_ctrl
//
// Reset sequencer for the Ara FPGA top level. It produces the debug-module
// reset and the SoC/UART reset in a staged order:
//   1. the PLL lock must be stable for LockHoldCycles cycles,
//   2. the debug module then leaves reset,
//   3. SocRstCycles cycles later the SoC leaves reset.
// An ndmreset request from the debug module puts only the SoC back into reset
// and stretches it to at least NdmMinCycles. The debug module keeps its state.
//
// Optional feature (macro ARA_FPGA_RST_LOCKMON_EN):
//   When defined, losing PLL lock after the debug module has been released
//   drops both resets and restarts the whole sequence (cause = 2).
//   When undefined, lock is only observed while waiting for the first lock.
//
// Ports:
//   clk_i        in   core clock (post-PLL BUFG)
//   rst_ni       in   asynchronous active-low board reset
//   pll_locked_i in   PLL LOCKED, asynchronous to clk_i (synchronized here)
//   ndmreset_i   in   debug-module ndmreset, synchronous to clk_i, active-high
//   dm_rst_no    out  active-low reset to dm_top
//   soc_rst_no   out  active-low reset to ara_soc and uart
//   rst_done_o   out  high while in RUN
//   state_o      out  current FSM state (0 WAIT_LOCK .. 4 NDM)
//   rst_cause_o  out  last cause: 0 board/power-on, 1 ndmreset, 2 PLL lock loss
// -----------------------------------------------------------------------------
module ara_fpga_rst_ctrl #(
    parameter int SyncStages     = 2,
    parameter int LockHoldCycles = 1024,
    parameter int SocRstCycles   = 64,
    parameter int NdmMinCycles   = 32
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       pll_locked_i,
    input  logic       ndmreset_i,
    output logic       dm_rst_no,
    output logic       soc_rst_no,
    output logic       rst_done_o,
    output logic [2:0] state_o,
    output logic [1:0] rst_cause_o
);

    localparam int MaxLs     = (LockHoldCycles > SocRstCycles) ? LockHoldCycles : SocRstCycles;
    localparam int MaxCycles = (MaxLs > NdmMinCycles) ? MaxLs : NdmMinCycles;
    localparam int CntW      = $clog2(MaxCycles) + 1;

    localparam logic [CntW-1:0] LockLast = CntW'(LockHoldCycles - 1);
    localparam logic [CntW-1:0] SocLast  = CntW'(SocRstCycles - 1);
    localparam logic [CntW-1:0] NdmLast  = CntW'(NdmMinCycles - 1);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        LOCK_HOLD = 3'd1,
        SOC_HOLD  = 3'd2,
        RUN       = 3'd3,
        NDM       = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [SyncStages-1:0] sync_q, sync_d;
    logic [1:0]            cause_q, cause_d;
    logic                  dm_rst_n_q, dm_rst_n_d;
    logic                  soc_rst_n_q, soc_rst_n_d;
    logic                  rst_done_q, rst_done_d;

    logic lock_s;
    logic lock_lost;
    logic cnt_inc;
    logic lock_drop;

    // PLL lock synchronizer: lock_s is the oldest stage.
    always_comb begin
        sync_d = {sync_q[SyncStages-2:0], pll_locked_i};
    end

    assign lock_s = sync_q[SyncStages-1];

`ifdef ARA_FPGA_RST_LOCKMON_EN
    assign lock_lost = ~lock_s;
`else
    // Lock is ignored once the debug module is out of reset.
    assign lock_lost = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_inc   = 1'b0;
        lock_drop = 1'b0;
        cause_d   = cause_q;

        // Priority inside each state: lock loss, then ndmreset, then count.
        case (state_q)
            WAIT_LOCK: begin
                if (lock_s) state_d = LOCK_HOLD;
            end
            LOCK_HOLD: begin
                if (!lock_s)                state_d = WAIT_LOCK;
                else if (cnt_q == LockLast) state_d = SOC_HOLD;
                else                        cnt_inc = 1'b1;
            end
            SOC_HOLD: begin
                if (lock_lost) begin
                    state_d   = WAIT_LOCK;
                    lock_drop = 1'b1;
                end else if (ndmreset_i) begin
                    state_d = NDM;
                end else if (cnt_q == SocLast) begin
                    state_d = RUN;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            RUN: begin
                if (lock_lost) begin
                    state_d   = WAIT_LOCK;
                    lock_drop = 1'b1;
                end else if (ndmreset_i) begin
                    state_d = NDM;
                end
            end
            NDM: begin
                if (lock_lost) begin
                    state_d   = WAIT_LOCK;
                    lock_drop = 1'b1;
                end else if (!ndmreset_i && (cnt_q >= NdmLast)) begin
                    state_d = SOC_HOLD;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                // Illegal encodings recover with both resets asserted.
                state_d = WAIT_LOCK;
            end
        endcase

        // Counter restarts on every transition and saturates at all-ones.
        if (state_d != state_q)           cnt_d = '0;
        else if (cnt_inc && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
        else                               cnt_d = cnt_q;

        if (lock_drop)                                 cause_d = 2'd2;
        else if ((state_d == NDM) && (state_q != NDM)) cause_d = 2'd1;

        // Outputs follow the next state so they switch on the transition edge.
        dm_rst_n_d  = (state_d == SOC_HOLD) || (state_d == RUN) || (state_d == NDM);
        soc_rst_n_d = (state_d == RUN);
        rst_done_d  = (state_d == RUN);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= WAIT_LOCK;
            cnt_q       <= '0;
            sync_q      <= '0;
            cause_q     <= 2'd0;
            dm_rst_n_q  <= 1'b0;
            soc_rst_n_q <= 1'b0;
            rst_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sync_q      <= sync_d;
            cause_q     <= cause_d;
            dm_rst_n_q  <= dm_rst_n_d;
            soc_rst_n_q <= soc_rst_n_d;
            rst_done_q  <= rst_done_d;
        end
    end

    assign dm_rst_no   = dm_rst_n_q;
    assign soc_rst_no  = soc_rst_n_q;
    assign rst_done_o  = rst_done_q;
    assign state_o     = state_q;
    assign rst_cause_o = cause_q;

endmodule

// File: tb/tb_ara_fpga_rst_ctrl.sv
module tb_ara_fpga_rst_ctrl;

    localparam int SYNC = 2;
    localparam int LHC  = 8;
    localparam int SRC  = 4;
    localparam int NMC  = 6;

`ifdef ARA_FPGA_RST_LOCKMON_EN
    localparam bit LOCKMON = 1'b1;
`else
    localparam bit LOCKMON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       pll_locked_i;
    logic       ndmreset_i;
    logic       dm_rst_no;
    logic       soc_rst_no;
    logic       rst_done_o;
    logic [2:0] state_o;
    logic [1:0] rst_cause_o;

    always #5 clk = ~clk;

    ara_fpga_rst_ctrl #(
        .SyncStages    (SYNC),
        .LockHoldCycles(LHC),
        .SocRstCycles  (SRC),
        .NdmMinCycles  (NMC)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .pll_locked_i(pll_locked_i),
        .ndmreset_i  (ndmreset_i),
        .dm_rst_no   (dm_rst_no),
        .soc_rst_no  (soc_rst_no),
        .rst_done_o  (rst_done_o),
        .state_o     (state_o),
        .rst_cause_o (rst_cause_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: phase plus the edge index at which it was entered.
    // Durations are judged from elapsed edges, lock_s is a plain delay line.
    // ------------------------------------------------------------------
    int m_phase;
    int m_cause;
    int m_enter;
    int cyc = 0;
    bit m_lockq[$];

    function automatic void model_reset();
        m_phase = 0;
        m_cause = 0;
        m_enter = cyc;
        m_lockq.delete();
        for (int i = 0; i < SYNC; i++) m_lockq.push_back(1'b0);
    endfunction

    function automatic void model_edge();
        bit ls;
        int nxt;
        int age;
        cyc++;
        if (!rst_ni) begin
            model_reset();
            return;
        end
        ls  = m_lockq[0];
        age = cyc - m_enter;
        nxt = m_phase;
        if (m_phase == 0) begin
            if (ls) nxt = 1;
        end else if (m_phase == 1) begin
            if (!ls) nxt = 0;
            else if (age == LHC) nxt = 2;
        end else if (LOCKMON && !ls) begin
            nxt = 0;
            m_cause = 2;
        end else if (m_phase == 2) begin
            if (ndmreset_i) nxt = 4;
            else if (age == SRC) nxt = 3;
        end else if (m_phase == 3) begin
            if (ndmreset_i) nxt = 4;
        end else begin
            if (!ndmreset_i && age >= NMC) nxt = 2;
        end
        if (nxt == 4 && m_phase != 4) m_cause = 1;
        if (nxt != m_phase) m_enter = cyc;
        m_phase = nxt;
        void'(m_lockq.pop_front());
        m_lockq.push_back(pll_locked_i);
    endfunction

    task automatic compare_model();
        chk("model.state", state_o, m_phase);
        chk("model.dm_rst_n", dm_rst_no, (m_phase == 2 || m_phase == 3 || m_phase == 4));
        chk("model.soc_rst_n", soc_rst_no, (m_phase == 3));
        chk("model.rst_done", rst_done_o, (m_phase == 3));
        chk("model.cause", rst_cause_o, m_cause);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string nm);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (state_o != s && n < budget);
        chk(nm, state_o, s);
    endtask

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic       rst_n;
        logic       pll;
        logic       ndm;
        logic [2:0] st;
        logic       dm;
        logic       soc;
        logic       done;
        logic [1:0] cause;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input int n, input logic r, input logic p, input logic d,
                                input logic [2:0] st, input logic dm, input logic soc,
                                input logic done, input logic [1:0] cause);
        vec_t v;
        v.rst_n = r; v.pll = p; v.ndm = d;
        v.st = st; v.dm = dm; v.soc = soc; v.done = done; v.cause = cause;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    initial begin
        int w;
        int n;
        bit saw0;
        int ndm_left;

        rst_ni       = 1'b1;
        pll_locked_i = 1'b1;
        ndmreset_i   = 1'b0;
        model_reset();
        #1;
        rst_ni = 1'b0;

        // Power-on sequence, then a one-cycle ndmreset in RUN.
        add(5,   1'b0, 1'b1, 1'b0,  3'd0, 1'b0, 1'b0, 1'b0, 2'd0);
        add(2,   1'b1, 1'b1, 1'b0,  3'd0, 1'b0, 1'b0, 1'b0, 2'd0);
        add(LHC, 1'b1, 1'b1, 1'b0,  3'd1, 1'b0, 1'b0, 1'b0, 2'd0);
        add(SRC, 1'b1, 1'b1, 1'b0,  3'd2, 1'b1, 1'b0, 1'b0, 2'd0);
        add(2,   1'b1, 1'b1, 1'b0,  3'd3, 1'b1, 1'b1, 1'b1, 2'd0);
        add(1,   1'b1, 1'b1, 1'b1,  3'd4, 1'b1, 1'b0, 1'b0, 2'd1);
        add(NMC-1, 1'b1, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 2'd1);
        add(SRC, 1'b1, 1'b1, 1'b0,  3'd2, 1'b1, 1'b0, 1'b0, 2'd1);
        add(2,   1'b1, 1'b1, 1'b0,  3'd3, 1'b1, 1'b1, 1'b1, 2'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            rst_ni       = vecs[i].rst_n;
            pll_locked_i = vecs[i].pll;
            ndmreset_i   = vecs[i].ndm;
            step();
            chk($sformatf("vec%0d.state", i), state_o, vecs[i].st);
            chk($sformatf("vec%0d.dm", i), dm_rst_no, vecs[i].dm);
            chk($sformatf("vec%0d.soc", i), soc_rst_no, vecs[i].soc);
            chk($sformatf("vec%0d.done", i), rst_done_o, vecs[i].done);
            chk($sformatf("vec%0d.cause", i), rst_cause_o, vecs[i].cause);
        end

        // Long ndmreset: 20 cycles high, SoC reset low for 20 + SocRstCycles.
        ndmreset_i = 1'b1;
        w = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!soc_rst_no) w++;
            chk("long_ndm.dm_stays", dm_rst_no, 1'b1);
        end
        ndmreset_i = 1'b0;
        n = 0;
        while (!soc_rst_no && n < 100) begin
            step();
            n++;
            if (!soc_rst_no) w++;
        end
        chk("long_ndm.width", w, 20 + SRC);

        // ndmreset arriving during SOC_HOLD goes straight back to NDM.
        ndmreset_i = 1'b1;
        step();
        ndmreset_i = 1'b0;
        wait_state(3'd2, 30, "ndm_pulse.to_soc_hold");
        ndmreset_i = 1'b1;
        step();
        ndmreset_i = 1'b0;
        chk("ndm_in_soc_hold.state", state_o, 3'd4);
        chk("ndm_in_soc_hold.dm", dm_rst_no, 1'b1);

        // Asynchronous reset at SOC_HOLD count 2, observed before the next edge.
        wait_state(3'd2, 30, "async.to_soc_hold");
        step();
        step();
        #3;
        rst_ni = 1'b0;
        #1;
        model_reset();
        chk("async.dm", dm_rst_no, 1'b0);
        chk("async.soc", soc_rst_no, 1'b0);
        chk("async.done", rst_done_o, 1'b0);
        chk("async.state", state_o, 3'd0);
        chk("async.cause", rst_cause_o, 2'd0);
        step();
        step();
        rst_ni = 1'b1;
        wait_state(3'd3, 40, "resequence.to_run");

        // Lock loss in RUN.
        pll_locked_i = 1'b0;
        step();
        step();
        step();
        if (LOCKMON) begin
            chk("lockloss.state", state_o, 3'd0);
            chk("lockloss.dm", dm_rst_no, 1'b0);
            chk("lockloss.soc", soc_rst_no, 1'b0);
            chk("lockloss.cause", rst_cause_o, 2'd2);
        end else begin
            chk("lockloss.state", state_o, 3'd3);
            chk("lockloss.dm", dm_rst_no, 1'b1);
            chk("lockloss.soc", soc_rst_no, 1'b1);
            chk("lockloss.cause", rst_cause_o, 2'd0);
        end
        pll_locked_i = 1'b1;
        wait_state(3'd3, 40, "lockloss.back_to_run");

        // Lock glitch during LOCK_HOLD restarts the full hold time.
        rst_ni = 1'b0;
        step();
        step();
        rst_ni = 1'b1;
        wait_state(3'd1, 20, "glitch.to_lock_hold");
        step();
        step();
        step();
        pll_locked_i = 1'b0;
        step();
        pll_locked_i = 1'b1;
        saw0 = 1'b0;
        for (int i = 0; i < 10 && !saw0; i++) begin
            step();
            chk("glitch.dm_low", dm_rst_no, 1'b0);
            if (state_o == 3'd0) saw0 = 1'b1;
        end
        chk("glitch.to_wait_lock", saw0, 1'b1);
        wait_state(3'd1, 20, "glitch.reenter");
        n = 0;
        while (!dm_rst_no && n < 30) begin
            step();
            n++;
        end
        chk("glitch.dm_delay", n, LHC);

        // Randomized traffic against the model.
        ndm_left = 0;
        for (int i = 0; i < 3000; i++) begin
            rst_ni       = ($urandom_range(0, 999) < 3) ? 1'b0 : 1'b1;
            pll_locked_i = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            if (ndm_left > 0) begin
                ndmreset_i = 1'b1;
                ndm_left--;
            end else if ($urandom_range(0, 99) < 4) begin
                ndmreset_i = 1'b1;
                ndm_left   = $urandom_range(0, 24);
            end else begin
                ndmreset_i = 1'b0;
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
